// File: rtl/block_pixel_feeder_pkg.sv
// Shared geometry, widths and the quadrant address mapping for the pixel feeder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package block_pixel_feeder_pkg;

    localparam int DATA_W     = 8;
    localparam int IMG_W      = 64;
    localparam int IMG_H      = 64;
    localparam int NUM_PE     = 4;
    localparam int NUM_PASSES = 2;
    localparam int BLOCK_SIZE = IMG_W * IMG_H / 4;
    localparam int ADDR_W     = $clog2(IMG_W * IMG_H);
    localparam int K_W        = $clog2(BLOCK_SIZE);
    localparam int Q_W        = $clog2(NUM_PE);
    localparam int PASS_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int HX_W       = $clog2(IMG_W / 2);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [K_W-1:0]    k_t;
    typedef logic [Q_W-1:0]    q_t;
    typedef logic [PASS_W-1:0] pass_t;
    typedef logic [DATA_W-1:0] pix_t;

    typedef struct packed {
        logic vld;
        q_t   tag;
        pix_t dat;
    } slot_t;

    // row*IMG_W+col collapses to a bit concatenation because both halves are powers of two
    function automatic addr_t quad_addr(input q_t q, input k_t k);
        return {q[1], k[K_W-1:HX_W], q[0], k[HX_W-1:0]};
    endfunction

endpackage

// File: rtl/block_pixel_feeder_if.sv
// Image-RAM read port and per-PE FIFO write port of the pixel feeder.
// Latency: n/a (wiring only).
// Backpressure: fifo_full per PE, driven by the FIFO side.
interface block_pixel_feeder_if;
    import block_pixel_feeder_pkg::*;

    logic              mem_rd_en;
    addr_t             mem_addr;
    pix_t              mem_rdata;
    logic [NUM_PE-1:0] fifo_wr_en;
    pix_t              fifo_wdata;
    logic [NUM_PE-1:0] fifo_full;

    modport master (
        output mem_rd_en, mem_addr, fifo_wr_en, fifo_wdata,
        input  mem_rdata, fifo_full
    );

    modport slave (
        input  mem_rd_en, mem_addr, fifo_wr_en, fifo_wdata,
        output mem_rdata, fifo_full
    );

endinterface

// File: rtl/block_pixel_feeder_quad_addr_gen.sv
// Pass/k/quadrant counters walking the block-interleaved read order; q fastest, then k, then pass.
// Latency: address is a function of the current counters; advances on the edge after adv_i.
// Backpressure: holds position while adv_i is low; wraps to zero after the last read.
module quad_addr_gen
    import block_pixel_feeder_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  adv_i,
    output addr_t addr_o,
    output q_t    q_o,
    output logic  last_o
);

    q_t    q_q, q_d;
    k_t    k_q, k_d;
    pass_t p_q, p_d;
    logic  q_end, k_end, p_end;

    always_comb begin
        q_end = (q_q == q_t'(NUM_PE - 1));
        k_end = (k_q == k_t'(BLOCK_SIZE - 1));
        p_end = (p_q == pass_t'(NUM_PASSES - 1));
        q_d   = q_q;
        k_d   = k_q;
        p_d   = p_q;
        if (adv_i) begin
            q_d = q_end ? '0 : q_q + q_t'(1);
            if (q_end) begin
                k_d = k_end ? '0 : k_q + k_t'(1);
                if (k_end) begin
                    p_d = p_end ? '0 : p_q + pass_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= '0;
            k_q <= '0;
            p_q <= '0;
        end else begin
            q_q <= q_d;
            k_q <= k_d;
            p_q <= p_d;
        end
    end

    assign addr_o = quad_addr(q_q, k_q);
    assign q_o    = q_q;
    assign last_o = q_end & k_end & p_end;

endmodule

// File: rtl/block_pixel_feeder.sv
// Streams the four image quadrants, NUM_PASSES times, from image RAM into the per-PE FIFOs.
// Latency: first FIFO write two cycles after the start-accept edge; 1 pixel/cycle when unstalled.
// Backpressure: a full target FIFO stalls the whole stream in order; reads pause until storage frees.
module block_pixel_feeder
    import block_pixel_feeder_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic busy,
    output logic done,
    block_pixel_feeder_if.master bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t     state_q;
    logic       inflight_q;
    q_t         inflight_tag_q;
    slot_t      hold_q;
    slot_t      skid_q;

    slot_t      ret;
    logic       wr;
    logic       issue;
    logic [1:0] occupancy;
    addr_t      gen_addr;
    q_t         gen_q;
    logic       gen_last;

    quad_addr_gen u_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .adv_i   (issue),
        .addr_o  (gen_addr),
        .q_o     (gen_q),
        .last_o  (gen_last)
    );

    // RAM data lives for one cycle only, so a read goes out only when hold+skid will have a slot for it.
    always_comb begin
        ret.vld   = inflight_q;
        ret.tag   = inflight_tag_q;
        ret.dat   = bus.mem_rdata;
        wr        = hold_q.vld & ~bus.fifo_full[hold_q.tag];
        occupancy = {1'b0, hold_q.vld} + {1'b0, skid_q.vld} + {1'b0, inflight_q} - {1'b0, wr};
        issue     = (state_q == ST_RUN) && (occupancy <= 2'd1);

        bus.fifo_wr_en = '0;
        if (wr) begin
            bus.fifo_wr_en[hold_q.tag] = 1'b1;
        end
        bus.fifo_wdata = hold_q.dat;
        bus.mem_rd_en  = issue;
        bus.mem_addr   = gen_addr;

        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DRAIN) && wr && !skid_q.vld && !inflight_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
            hold_q         <= '0;
            skid_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE:  if (start)              state_q <= ST_RUN;
                ST_RUN:   if (issue && gen_last)  state_q <= ST_DRAIN;
                ST_DRAIN: if (done)               state_q <= ST_IDLE;
                default:                          state_q <= ST_IDLE;
            endcase

            inflight_q     <= issue;
            inflight_tag_q <= gen_q;

            if (!hold_q.vld || wr) begin
                if (skid_q.vld) begin
                    hold_q <= skid_q;
                    skid_q <= ret;
                end else if (ret.vld) begin
                    hold_q <= ret;
                end else begin
                    hold_q.vld <= 1'b0;
                end
            end else if (ret.vld) begin
                skid_q <= ret;
            end
        end
    end

endmodule
